// File: rtl/rom_load_ctrl_if.sv
// Download / ROM-write bus for the ROM load controller.
// master = download source, slave = controller.
interface rom_load_ctrl_if;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_en;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    input  wr_addr, wr_data, wr_en
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    output wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/rom_load_ctrl.sv
// ROM download controller: splits the image into four ROM regions,
// validates the download and stretches the core reset afterwards.
module rom_load_ctrl #(
  parameter logic [15:0] R1_BASE     = 16'h6000,
  parameter logic [15:0] R2_BASE     = 16'h7000,
  parameter logic [15:0] R3_BASE     = 16'h8000,
  parameter logic [15:0] R3_END      = 16'h805F,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic           clk_sys,
  input  logic           reset,
  rom_load_ctrl_if.slave bus,
  input  logic           user_reset,
  output logic           core_reset,
  output logic           load_ok,
  output logic           load_err
);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    LOAD
  } state_t;

  localparam logic [10:0] HOLD_LAST = 11'(HOLD_CYCLES - 1);
  localparam logic [16:0] IMG_SIZE  = 17'(R3_END) + 17'd1;

  state_t      state;
  state_t      state_nx;
  logic [10:0] hold_cnt;
  logic [10:0] hold_nx;
  logic [16:0] byte_cnt;
  logic [16:0] cnt_inc;
  logic        err_inc;

  logic [15:0] a16;
  logic        accept;
  logic        in_range;
  logic        valid;
  logic        bad;
  logic [3:0]  hit;
  logic [15:0] base;

  assign a16      = bus.dl_addr[15:0];
  assign accept   = (state == LOAD) && bus.dl_wr;
  assign in_range = (bus.dl_addr[24:16] == 9'd0) && (a16 <= R3_END);
  assign valid    = accept && in_range;
  assign bad      = accept && !in_range;

  // Region select: highest base not above the address.
  always_comb begin
    hit  = 4'b0001;
    base = 16'h0000;
    if (a16 >= R3_BASE) begin
      hit  = 4'b1000;
      base = R3_BASE;
    end else if (a16 >= R2_BASE) begin
      hit  = 4'b0100;
      base = R2_BASE;
    end else if (a16 >= R1_BASE) begin
      hit  = 4'b0010;
      base = R1_BASE;
    end
  end

  // Counter/flag values including this cycle's write, so a write
  // coinciding with the dl_active fall is still counted.
  always_comb begin
    cnt_inc = byte_cnt;
    if (valid && byte_cnt != 17'h1FFFF)
      cnt_inc = byte_cnt + 17'd1;
    err_inc = load_err | bad;
  end

  // Next-state and hold-counter logic.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    case (state)
      HOLD: begin
        if (bus.dl_active)
          state_nx = LOAD;
        else if (user_reset)
          hold_nx = 11'd0;
        else if (hold_cnt == HOLD_LAST)
          state_nx = RUN;
        else
          hold_nx = hold_cnt + 11'd1;
      end
      RUN: begin
        if (bus.dl_active) begin
          state_nx = LOAD;
        end else if (user_reset) begin
          state_nx = HOLD;
          hold_nx  = 11'd0;
        end
      end
      LOAD: begin
        if (!bus.dl_active) begin
          state_nx = HOLD;
          hold_nx  = 11'd0;
        end
      end
      default: begin
        state_nx = HOLD;
        hold_nx  = 11'd0;
      end
    endcase
  end

  // State and hold counter registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= 11'd0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Download bookkeeping: byte count, error flag, completion flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      byte_cnt <= 17'd0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else if (state != LOAD && state_nx == LOAD) begin
      byte_cnt <= 17'd0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else if (state == LOAD) begin
      byte_cnt <= cnt_inc;
      load_err <= err_inc;
      if (!bus.dl_active)
        load_ok <= (cnt_inc == IMG_SIZE) && !err_inc;
    end
  end

  // Registered ROM write port, one-cycle enable per valid byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.wr_en   <= 4'b0000;
      bus.wr_addr <= 16'h0000;
      bus.wr_data <= 8'h00;
    end else begin
      bus.wr_en <= valid ? hit : 4'b0000;
      if (valid) begin
        bus.wr_addr <= a16 - base;
        bus.wr_data <= bus.dl_data;
      end
    end
  end

  assign core_reset = (state != RUN);

endmodule
